// File: rtl/mor1kx_pic_vectored.sv
// Vectored programmable interrupt controller for mor1kx (SPR group 9).
// Per-line level/edge trigger, W1C edge status, registered SPR ack and priority ID.
module mor1kx_pic_vectored #(
  parameter int          NUM_IRQ              = 32,
  parameter int          OPTION_PIC_NMI_WIDTH = 0,
  parameter int          SYNC_STAGES          = 2,
  parameter logic [31:0] TRIGGER_RESET        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irq_i,
  input  logic        spr_access_i,
  input  logic        spr_we_i,
  input  logic [15:0] spr_addr_i,
  input  logic [31:0] spr_dat_i,
  output logic        spr_bus_ack,
  output logic [31:0] spr_dat_o,
  output logic [31:0] spr_picmr_o,
  output logic [31:0] spr_picsr_o,
  output logic        irq_o,
  output logic [4:0]  irq_id_o
);

  localparam logic [31:0] IMPL_MASK = 32'((64'd1 << NUM_IRQ) - 64'd1);
  localparam logic [31:0] NMI_MASK  = 32'((64'd1 << OPTION_PIC_NMI_WIDTH) - 64'd1);

  localparam logic [10:0] OFF_PICMR = 11'h000;
  localparam logic [10:0] OFF_PICSR = 11'h002;
  localparam logic [10:0] OFF_PICTR = 11'h003;

  logic [31:0] irq_s;
  logic [31:0] picmr;
  logic [31:0] pictr;
  logic [31:0] edge_sr;
  logic [31:0] prev;
  logic [31:0] unmasked;
  logic [31:0] rise;
  logic [31:0] picsr;
  logic [31:0] clr;
  logic [31:0] rd_data;
  logic [4:0]  irq_id_next;
  logic        access;
  logic [10:0] offset;
  logic        unused_addr;

  // The group bits are already qualified by whoever raises spr_access_i.
  assign unused_addr = ^spr_addr_i[15:11];
  assign offset      = spr_addr_i[10:0];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = irq_i & IMPL_MASK;
    end else begin : g_sync
      logic [31:0] stage [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) stage[k] <= '0;
        end else begin
          stage[0] <= irq_i & IMPL_MASK;
          for (int k = 1; k < SYNC_STAGES; k++) stage[k] <= stage[k-1];
        end
      end
      assign irq_s = stage[SYNC_STAGES-1];
    end
  endgenerate

  // Handshake: an access executes in the first cycle spr_access_i=1 with no ack
  // pending; spr_bus_ack and spr_dat_o are valid for exactly the following cycle.
  assign access = spr_access_i && !spr_bus_ack;

  assign unmasked = irq_s & picmr;
  assign rise     = unmasked & ~prev;
  assign clr      = (access && spr_we_i && offset == OFF_PICSR) ? spr_dat_i : '0;
  assign picsr    = (unmasked & ~pictr) | (edge_sr & pictr);

  assign spr_picmr_o = picmr;
  assign spr_picsr_o = picsr;

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_PICMR: rd_data = picmr;
      OFF_PICSR: rd_data = picsr;
      OFF_PICTR: rd_data = pictr;
      default:   rd_data = '0;
    endcase
  end

  always_comb begin
    irq_id_next = '0;
    for (int i = 31; i >= 0; i--) begin
      if (picsr[i]) irq_id_next = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      picmr       <= NMI_MASK;
      pictr       <= TRIGGER_RESET & IMPL_MASK;
      edge_sr     <= '0;
      prev        <= '0;
      spr_bus_ack <= 1'b0;
      spr_dat_o   <= '0;
      irq_o       <= 1'b0;
      irq_id_o    <= '0;
    end else begin
      prev <= unmasked;
      // Level lines hold no latch, so a later switch to edge starts clean; set beats clear.
      edge_sr     <= pictr & (rise | (edge_sr & ~clr));
      spr_bus_ack <= access;
      spr_dat_o   <= (access && !spr_we_i) ? rd_data : '0;
      if (access && spr_we_i && offset == OFF_PICMR) picmr <= (spr_dat_i & IMPL_MASK) | NMI_MASK;
      if (access && spr_we_i && offset == OFF_PICTR) pictr <= spr_dat_i & IMPL_MASK;
      irq_o    <= |picsr;
      irq_id_o <= irq_id_next;
    end
  end

endmodule

// File: tb/tb_mor1kx_pic_vectored.sv
// Self-checking bench for mor1kx_pic_vectored: cycle reference model plus directed cases.
module tb_mor1kx_pic_vectored;

  localparam logic [31:0] TRIG_A = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // instance A: 32 lines, 2 sync stages, no NMI
  logic [31:0] irq_a;
  logic        a_access, a_we, a_ack, a_irq_o;
  logic [15:0] a_addr;
  logic [31:0] a_wdat, a_rdat, a_picmr, a_picsr;
  logic [4:0]  a_id;

  // instance B: 8 lines, no synchroniser, 2 NMI lines
  logic [31:0] irq_b;
  logic        b_access, b_we, b_ack, b_irq_o;
  logic [15:0] b_addr;
  logic [31:0] b_wdat, b_rdat, b_picmr, b_picsr;
  logic [4:0]  b_id;

  mor1kx_pic_vectored #(
    .NUM_IRQ(32), .OPTION_PIC_NMI_WIDTH(0), .SYNC_STAGES(2), .TRIGGER_RESET(TRIG_A)
  ) dut_a (
    .clk(clk), .rst(rst), .irq_i(irq_a),
    .spr_access_i(a_access), .spr_we_i(a_we), .spr_addr_i(a_addr), .spr_dat_i(a_wdat),
    .spr_bus_ack(a_ack), .spr_dat_o(a_rdat), .spr_picmr_o(a_picmr), .spr_picsr_o(a_picsr),
    .irq_o(a_irq_o), .irq_id_o(a_id)
  );

  mor1kx_pic_vectored #(
    .NUM_IRQ(8), .OPTION_PIC_NMI_WIDTH(2), .SYNC_STAGES(0), .TRIGGER_RESET(32'h0000_0F05)
  ) dut_b (
    .clk(clk), .rst(rst), .irq_i(irq_b),
    .spr_access_i(b_access), .spr_we_i(b_we), .spr_addr_i(b_addr), .spr_dat_i(b_wdat),
    .spr_bus_ack(b_ack), .spr_dat_o(b_rdat), .spr_picmr_o(b_picmr), .spr_picsr_o(b_picsr),
    .irq_o(b_irq_o), .irq_id_o(b_id)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit (%0d tests, %0d failed)", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model of instance A: state as seen after each clock edge
  typedef struct packed {
    logic [31:0] h_old;   // synchronised line value (two clocks old)
    logic [31:0] h_new;
    logic [31:0] picmr;
    logic [31:0] pictr;
    logic [31:0] edg;
    logic [31:0] prev;
    logic        ack;
    logic        irq;
    logic [4:0]  id;
  } model_t;

  model_t m;

  function automatic model_t m_reset();
    model_t n;
    n = '0;
    n.pictr = TRIG_A;
    return n;
  endfunction

  function automatic logic [31:0] m_sr(input model_t s);
    logic [31:0] sr;
    sr = '0;
    for (int i = 0; i < 32; i++) begin
      if (s.pictr[i]) sr[i] = s.edg[i];
      else            sr[i] = s.h_old[i] & s.picmr[i];
    end
    return sr;
  endfunction

  function automatic logic [31:0] m_read(input model_t s, input logic we, input logic [15:0] addr);
    if (we) return '0;
    case (addr[10:0])
      11'h000: return s.picmr;
      11'h002: return m_sr(s);
      11'h003: return s.pictr;
      default: return '0;
    endcase
  endfunction

  function automatic model_t m_step(input model_t s, input logic [31:0] irq, input logic acc_in,
                                    input logic we, input logic [15:0] addr, input logic [31:0] dat);
    model_t      n;
    logic [31:0] sr;
    logic        acc;
    logic        u;
    int          k;
    n   = s;
    sr  = m_sr(s);
    acc = acc_in && !s.ack;
    for (int i = 0; i < 32; i++) begin
      u = s.h_old[i] & s.picmr[i];
      if (!s.pictr[i])                                n.edg[i] = 1'b0;
      else if (u && !s.prev[i])                       n.edg[i] = 1'b1;
      else if (acc && we && addr[10:0] == 11'h002 && dat[i]) n.edg[i] = 1'b0;
      n.prev[i] = u;
    end
    n.irq = (sr != 0);
    k = 0;
    while (k < 32 && !sr[k]) k++;
    n.id  = (k == 32) ? 5'd0 : 5'(k);
    n.ack = acc;
    if (acc && we && addr[10:0] == 11'h000) n.picmr = dat;
    if (acc && we && addr[10:0] == 11'h003) n.pictr = dat;
    n.h_old = s.h_new;
    n.h_new = irq;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= m_reset();
      exp_q.delete();
    end else begin
      if (a_access && !m.ack) exp_q.push_back(m_read(m, a_we, a_addr));
      m <= m_step(m, irq_a, a_access, a_we, a_addr, a_wdat);
    end
  end

  // scoreboard: every output of instance A against the model, away from the clock edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("a_ack", 32'(a_ack), 32'(m.ack));
      if (m.ack && exp_q.size() > 0) check_eq("a_rdata", a_rdat, exp_q.pop_front());
      else                           check_eq("a_rdata_idle", a_rdat, 32'd0);
      check_eq("a_picmr", a_picmr, m.picmr);
      check_eq("a_picsr", a_picsr, m_sr(m));
      check_eq("a_irq", 32'(a_irq_o), 32'(m.irq));
      check_eq("a_id", 32'(a_id), 32'(m.id));
    end
  end

  // drivers
  task automatic spr_a(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                       input logic hold, output logic [31:0] rdata);
    @(negedge clk);
    a_access = 1'b1; a_we = we; a_addr = addr; a_wdat = dat;
    @(negedge clk);
    rdata = a_rdat;
    if (!hold) a_access = 1'b0;
    @(negedge clk);
    a_access = 1'b0;
  endtask

  task automatic spr_b(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                       output logic [31:0] rdata);
    @(negedge clk);
    b_access = 1'b1; b_we = we; b_addr = addr; b_wdat = dat;
    @(negedge clk);
    check_eq("b_ack", 32'(b_ack), 32'd1);
    rdata = b_rdat;
    b_access = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] addrs [5] = '{16'h4800, 16'h4802, 16'h4803, 16'h4805, 16'h4801};

  initial begin
    logic [31:0] rd;
    rst = 1'b0;
    irq_a = '0; a_access = 1'b0; a_we = 1'b0; a_addr = '0; a_wdat = '0;
    irq_b = '0; b_access = 1'b0; b_we = 1'b0; b_addr = '0; b_wdat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    check_eq("rst_ack", 32'(a_ack), 32'd0);
    check_eq("rst_irq", 32'(a_irq_o), 32'd0);
    check_eq("rst_picmr", a_picmr, 32'd0);
    check_eq("rst_b_picmr", b_picmr, 32'h3);
    chk_en = 1'b1;

    // SPR timing and decode
    spr_a(1'b0, 16'h4803, '0, 1'b0, rd); check_eq("pictr_rst_read", rd, TRIG_A);
    spr_a(1'b1, 16'h4805, 32'hFFFF_FFFF, 1'b0, rd);
    spr_a(1'b0, 16'h4805, '0, 1'b0, rd); check_eq("unmapped_read", rd, 32'd0);
    spr_a(1'b0, 16'h4800, '0, 1'b0, rd); check_eq("picmr_untouched", rd, 32'd0);

    // level line latency
    spr_a(1'b1, 16'h4803, 32'h0, 1'b0, rd);
    spr_a(1'b1, 16'h4800, 32'h10, 1'b0, rd);
    irq_a[4] = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("lvl_irq_early", 32'(a_irq_o), 32'd0);
    @(negedge clk);
    check_eq("lvl_irq_on", 32'(a_irq_o), 32'd1);
    check_eq("lvl_id4", 32'(a_id), 32'd4);
    irq_a[4] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("lvl_irq_hold", 32'(a_irq_o), 32'd1);
    @(negedge clk);
    check_eq("lvl_irq_off", 32'(a_irq_o), 32'd0);

    // edge line: latch, W1C, set-beats-clear
    spr_a(1'b1, 16'h4803, 32'h1, 1'b0, rd);
    spr_a(1'b1, 16'h4800, 32'h1, 1'b0, rd);
    irq_a[0] = 1'b1;
    @(negedge clk);
    irq_a[0] = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("edge_latched", a_picsr, 32'h1);
    spr_a(1'b1, 16'h4802, 32'h1, 1'b0, rd);
    check_eq("edge_cleared", a_picsr, 32'h0);
    check_eq("edge_irq_off", 32'(a_irq_o), 32'd0);
    irq_a[0] = 1'b1;
    @(negedge clk);
    irq_a[0] = 1'b0;
    spr_a(1'b1, 16'h4802, 32'h1, 1'b0, rd);
    check_eq("set_beats_clear", a_picsr, 32'h1);
    spr_a(1'b1, 16'h4802, 32'h1, 1'b0, rd);

    // priority 3 vs 9, then mask 3
    spr_a(1'b1, 16'h4803, 32'h0, 1'b0, rd);
    spr_a(1'b1, 16'h4800, 32'h208, 1'b0, rd);
    irq_a[3] = 1'b1; irq_a[9] = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("prio_id3", 32'(a_id), 32'd3);
    spr_a(1'b1, 16'h4800, 32'h200, 1'b0, rd);
    check_eq("prio_id9", 32'(a_id), 32'd9);
    irq_a = '0;

    // unmask-as-edge, then edge->level
    spr_a(1'b1, 16'h4800, 32'h0, 1'b0, rd);
    spr_a(1'b1, 16'h4803, 32'h40, 1'b0, rd);
    irq_a[6] = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("l6_masked", a_picsr, 32'h0);
    spr_a(1'b1, 16'h4800, 32'h40, 1'b0, rd);
    check_eq("l6_unmask_edge", a_picsr, 32'h40);
    spr_a(1'b1, 16'h4803, 32'h0, 1'b0, rd);
    check_eq("l6_level_follow", a_picsr, 32'h40);
    irq_a[6] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("l6_latch_gone", a_picsr, 32'h0);

    // instance B: NMI and line-count masking, no synchroniser
    spr_b(1'b0, 16'h4800, '0, rd);           check_eq("b_picmr_rst_read", rd, 32'h3);
    spr_b(1'b1, 16'h4800, 32'h0, rd);
    spr_b(1'b0, 16'h4800, '0, rd);           check_eq("b_nmi_kept", rd, 32'h3);
    spr_b(1'b1, 16'h4800, 32'hF0, rd);
    spr_b(1'b0, 16'h4800, '0, rd);           check_eq("b_picmr_f3", rd, 32'hF3);
    spr_b(1'b1, 16'h4800, 32'hFFFF_FFFF, rd);
    spr_b(1'b0, 16'h4800, '0, rd);           check_eq("b_picmr_ff", rd, 32'hFF);
    spr_b(1'b0, 16'h4803, '0, rd);           check_eq("b_pictr_rst", rd, 32'h05);
    spr_b(1'b1, 16'h4803, 32'h0, rd);
    irq_b = 32'h80;
    #1 check_eq("b_picsr_comb", b_picsr, 32'h80);
    @(negedge clk);
    check_eq("b_irq_on", 32'(b_irq_o), 32'd1);
    check_eq("b_id7", 32'(b_id), 32'd7);
    irq_b = 32'h0010_0000;
    #1 check_eq("b_high_ignored", b_picsr, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("b_irq_off", 32'(b_irq_o), 32'd0);

    // randomized traffic on instance A, checked every cycle by the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) irq_a = $urandom();
      else                           irq_a = irq_a ^ (32'(1) << $urandom_range(0, 31));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      spr_a(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 4)], $urandom(),
            1'($urandom_range(0, 1)), rd);
    end

    // reset between access and ack
    spr_a(1'b1, 16'h4803, 32'h0, 1'b0, rd);
    spr_a(1'b1, 16'h4800, 32'h1, 1'b0, rd);
    irq_a = 32'h1;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_irq", 32'(a_irq_o), 32'd1);
    a_access = 1'b1; a_we = 1'b0; a_addr = 16'h4800;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_ack", 32'(a_ack), 32'd0);
    check_eq("mid_rst_rdat", a_rdat, 32'd0);
    check_eq("mid_rst_irq", 32'(a_irq_o), 32'd0);
    check_eq("mid_rst_id", 32'(a_id), 32'd0);
    a_access = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    spr_a(1'b0, 16'h4800, '0, 1'b0, rd);    check_eq("post_rst_picmr", rd, 32'h0);
    spr_a(1'b0, 16'h4803, '0, 1'b0, rd);    check_eq("post_rst_pictr", rd, TRIG_A);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
